// File: rtl/core_flags_pkg.sv
// Shared condition codes, flag bit positions and the branch-condition evaluator.
package core_flags_pkg;

  localparam int FLAG_W = 4;

  localparam int CORE_FLAG_Z = 0;
  localparam int CORE_FLAG_C = 1;
  localparam int CORE_FLAG_V = 2;
  localparam int CORE_FLAG_N = 3;

  localparam logic [3:0] CORE_COND_AL = 4'd0;
  localparam logic [3:0] CORE_COND_NV = 4'd1;
  localparam logic [3:0] CORE_COND_EQ = 4'd2;
  localparam logic [3:0] CORE_COND_NE = 4'd3;
  localparam logic [3:0] CORE_COND_CS = 4'd4;
  localparam logic [3:0] CORE_COND_CC = 4'd5;
  localparam logic [3:0] CORE_COND_VS = 4'd6;
  localparam logic [3:0] CORE_COND_VC = 4'd7;
  localparam logic [3:0] CORE_COND_HI = 4'd8;
  localparam logic [3:0] CORE_COND_LS = 4'd9;
  localparam logic [3:0] CORE_COND_GE = 4'd10;
  localparam logic [3:0] CORE_COND_LT = 4'd11;
  localparam logic [3:0] CORE_COND_GT = 4'd12;
  localparam logic [3:0] CORE_COND_LE = 4'd13;

  typedef struct packed {
    logic taken;
    logic illegal;
  } cond_res_t;

  function automatic cond_res_t eval_cond(input logic [3:0] cond,
                                          input logic [FLAG_W-1:0] f);
    logic n, v, c, z;
    cond_res_t r;
    n = f[CORE_FLAG_N];
    v = f[CORE_FLAG_V];
    c = f[CORE_FLAG_C];
    z = f[CORE_FLAG_Z];
    r = '0;
    case (cond)
      CORE_COND_AL: r.taken = 1'b1;
      CORE_COND_NV: r.taken = 1'b0;
      CORE_COND_EQ: r.taken = z;
      CORE_COND_NE: r.taken = !z;
      CORE_COND_CS: r.taken = c;
      CORE_COND_CC: r.taken = !c;
      CORE_COND_VS: r.taken = v;
      CORE_COND_VC: r.taken = !v;
      CORE_COND_HI: r.taken = !c && !z;
      CORE_COND_LS: r.taken = c || z;
      CORE_COND_GE: r.taken = (n == v);
      CORE_COND_LT: r.taken = (n != v);
      CORE_COND_GT: r.taken = !z && (n == v);
      CORE_COND_LE: r.taken = z || (n != v);
      default:      r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_flag_stack.sv
// LIFO of saved flag words for exception nesting; rejected push/pop is reported
// combinationally on rej_o and leaves the stack untouched.
module core_flag_stack
  import core_flags_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [FLAG_W-1:0] din_i,
  output logic [FLAG_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       depth_o,
  output logic              rej_o
);

  logic [FLAG_W-1:0] mem_q [DEPTH];
  logic [AW:0]       depth_q, depth_d;
  logic [AW-1:0]     top_idx;

  assign full_o  = (depth_q == (AW+1)'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign dout_o  = mem_q[top_idx];
  assign rej_o   = (push_i && full_o) || (pop_i && empty_o);

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o)
      depth_d = depth_q + (AW+1)'(1);
    else if (pop_i && !empty_o)
      depth_d = depth_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) depth_q <= '0;
    else          depth_q <= depth_d;
  end

  // Contents need no reset; only depth_q defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o)
      mem_q[depth_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/core_flags.sv
// Architectural {n,v,c,z} flag register with exception save/restore stack and a
// registered branch-condition evaluator (one result per query, next cycle).
module core_flags
  import core_flags_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flag_we_i,
  input  logic              cf_i,
  input  logic              of_i,
  input  logic              zf_i,
  input  logic              nf_i,
  input  logic              cond_valid_i,
  input  logic [3:0]        cond_i,
  output logic              taken_valid_o,
  output logic              taken_o,
  output logic              cond_illegal_o,
  input  logic              exc_enter_i,
  input  logic              exc_return_i,
  output logic [FLAG_W-1:0] flags_o,
  output logic [AW:0]       stk_depth_o,
  output logic              stk_err_o
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] flags_in, flags_eff, stk_dout;
  logic              tv_q, taken_q, taken_d, ill_q, ill_d;
  logic              err_q, err_d;
  logic              stk_full, stk_empty, stk_rej, stk_pop;
  cond_res_t         res;

  assign flags_in  = {nf_i, of_i, cf_i, zf_i};
  // Forwarded view: used both for the pushed entry and for query evaluation.
  assign flags_eff = flag_we_i ? flags_in : flags_q;
  assign stk_pop   = exc_return_i && !exc_enter_i;
  assign res       = eval_cond(cond_i, flags_eff);

  core_flag_stack #(.DEPTH(DEPTH)) u_stack (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (exc_enter_i),
    .pop_i   (stk_pop),
    .din_i   (flags_eff),
    .dout_o  (stk_dout),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .depth_o (stk_depth_o),
    .rej_o   (stk_rej)
  );

  always_comb begin
    flags_d = flags_q;
    if (exc_enter_i)
      flags_d = '0;
    else if (exc_return_i) begin
      if (!stk_empty) flags_d = stk_dout;
    end else if (flag_we_i)
      flags_d = flags_in;
  end

  always_comb begin
    err_d   = err_q || stk_rej || (exc_enter_i && exc_return_i);
    taken_d = taken_q;
    ill_d   = ill_q;
    if (cond_valid_i) begin
      taken_d = res.taken;
      ill_d   = res.illegal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      flags_q <= '0;
      tv_q    <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      tv_q    <= cond_valid_i;
      taken_q <= taken_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  assign flags_o        = flags_q;
  assign taken_valid_o  = tv_q;
  assign taken_o        = taken_q;
  assign cond_illegal_o = ill_q;
  assign stk_err_o      = err_q;

endmodule

// File: tb/tb_core_flags.sv
// Directed-vector bench for core_flags (DEPTH=4): inputs driven 1 time unit after
// each rising edge, outputs sampled 1 time unit after the following edge.
module tb_core_flags;
  import core_flags_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flag_we = 1'b0, cf = 1'b0, of = 1'b0, zf = 1'b0, nf = 1'b0;
  logic       cond_valid = 1'b0;
  logic [3:0] cond = 4'd0;
  logic       exc_enter = 1'b0, exc_return = 1'b0;
  logic       taken_valid, taken, cond_illegal, stk_err;
  logic [3:0] flags;
  logic [2:0] stk_depth;

  int n_chk = 0;
  int n_fail = 0;

  core_flags #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flag_we_i(flag_we), .cf_i(cf), .of_i(of),
    .zf_i(zf), .nf_i(nf), .cond_valid_i(cond_valid), .cond_i(cond),
    .taken_valid_o(taken_valid), .taken_o(taken), .cond_illegal_o(cond_illegal),
    .exc_enter_i(exc_enter), .exc_return_i(exc_return), .flags_o(flags),
    .stk_depth_o(stk_depth), .stk_err_o(stk_err)
  );

  always #5 clk = ~clk;

  // One cycle: drive {we,flags(nvcz),cv,cond,enter,return}, clock, clear strobes.
  task automatic cyc(input logic we, input logic [3:0] f, input logic cv,
                     input logic [3:0] c, input logic en, input logic ret);
    flag_we = we; {nf, of, cf, zf} = f; cond_valid = cv; cond = c;
    exc_enter = en; exc_return = ret;
    @(posedge clk); #1;
    flag_we = 1'b0; cond_valid = 1'b0; exc_enter = 1'b0; exc_return = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic query(input logic [3:0] c, input logic exp_t, input logic exp_i, input string nm);
    cyc(1'b0, 4'b0, 1'b1, c, 1'b0, 1'b0);
    n_chk++;
    if (taken_valid !== 1'b1 || taken !== exp_t || cond_illegal !== exp_i) begin
      n_fail++;
      $display("FAIL %s: got tv=%b taken=%b ill=%b want tv=1 taken=%b ill=%b",
               nm, taken_valid, taken, cond_illegal, exp_t, exp_i);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({flags, taken_valid, taken, cond_illegal, stk_depth, stk_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset: got flags=%b tv=%b t=%b ill=%b depth=%0d err=%b want all 0",
               flags, taken_valid, taken, cond_illegal, stk_depth, stk_err);
    end
  endtask

  task automatic test_basic();
    cyc(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
    n_chk++;
    if (flags !== 4'b0001) begin n_fail++; $display("FAIL basic_flags: got %b want 0001", flags); end
    query(CORE_COND_EQ, 1'b1, 1'b0, "basic_eq");
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_chk++;
    if (taken_valid !== 1'b0 || taken !== 1'b1) begin
      n_fail++; $display("FAIL pulse_hold: got tv=%b taken=%b want tv=0 taken=1", taken_valid, taken);
    end
  endtask

  task automatic test_forward();
    do_reset();
    cyc(1'b1, 4'b0001, 1'b1, CORE_COND_NE, 1'b0, 1'b0);
    n_chk++;
    if (taken_valid !== 1'b1 || taken !== 1'b0 || flags !== 4'b0001) begin
      n_fail++; $display("FAIL forward_ne: got tv=%b taken=%b flags=%b want 1 0 0001", taken_valid, taken, flags);
    end
  endtask

  task automatic test_conds();
    do_reset();
    cyc(1'b1, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
    query(CORE_COND_GE, 1'b0, 1'b0, "ge_n1v0");
    query(CORE_COND_LT, 1'b1, 1'b0, "lt_n1v0");
    query(CORE_COND_GT, 1'b0, 1'b0, "gt_n1v0");
    query(CORE_COND_LE, 1'b1, 1'b0, "le_n1v0");
    cyc(1'b1, 4'b1100, 1'b0, 4'd0, 1'b0, 1'b0);
    query(CORE_COND_GE, 1'b1, 1'b0, "ge_n1v1");
    query(CORE_COND_HI, 1'b1, 1'b0, "hi_c0z0");
    query(CORE_COND_VS, 1'b1, 1'b0, "vs_v1");
    query(CORE_COND_CS, 1'b0, 1'b0, "cs_c0");
    query(4'd14, 1'b0, 1'b1, "reserved14");
    query(CORE_COND_AL, 1'b1, 1'b0, "al");
    query(4'd15, 1'b0, 1'b1, "reserved15");
    query(CORE_COND_NV, 1'b0, 1'b0, "nv");
    cyc(1'b1, 4'b0011, 1'b0, 4'd0, 1'b0, 1'b0);
    query(CORE_COND_LS, 1'b1, 1'b0, "ls_c1z1");
    query(CORE_COND_HI, 1'b0, 1'b0, "hi_c1z1");
  endtask

  task automatic test_nesting();
    do_reset();
    cyc(1'b1, 4'b1010, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    n_chk++;
    if (flags !== 4'b0 || stk_depth !== 3'd1) begin
      n_fail++; $display("FAIL nest_enter1: got flags=%b depth=%0d want 0000 1", flags, stk_depth);
    end
    cyc(1'b1, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    n_chk++;
    if (stk_depth !== 3'd2) begin n_fail++; $display("FAIL nest_enter2: got depth=%0d want 2", stk_depth); end
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    n_chk++;
    if (flags !== 4'b0101 || stk_depth !== 3'd1) begin
      n_fail++; $display("FAIL nest_ret1: got flags=%b depth=%0d want 0101 1", flags, stk_depth);
    end
    // A same-cycle flag write loses to the return.
    cyc(1'b1, 4'b1111, 1'b0, 4'd0, 1'b0, 1'b1);
    n_chk++;
    if (flags !== 4'b1010 || stk_depth !== 3'd0 || stk_err !== 1'b0) begin
      n_fail++; $display("FAIL nest_ret2: got flags=%b depth=%0d err=%b want 1010 0 0", flags, stk_depth, stk_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0110, 1'b0, 4'd0, 1'b1, 1'b0);
    n_chk++;
    if (stk_depth !== 3'd4 || stk_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill: got depth=%0d err=%b want 4 0", stk_depth, stk_err);
    end
    cyc(1'b1, 4'b0110, 1'b0, 4'd0, 1'b1, 1'b0);
    n_chk++;
    if (stk_depth !== 3'd4 || stk_err !== 1'b1 || flags !== 4'b0) begin
      n_fail++; $display("FAIL ovf_fifth: got depth=%0d err=%b flags=%b want 4 1 0000", stk_depth, stk_err, flags);
    end
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    n_chk++;
    if (flags !== 4'b0110 || stk_depth !== 3'd3 || stk_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pop_sticky: got flags=%b depth=%0d err=%b want 0110 3 1", flags, stk_depth, stk_err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    n_chk++;
    if (flags !== 4'b0110 || stk_err !== 1'b1 || stk_depth !== 3'd0) begin
      n_fail++; $display("FAIL underflow: got flags=%b err=%b depth=%0d want 0110 1 0", flags, stk_err, stk_depth);
    end
  endtask

  task automatic test_collisions();
    do_reset();
    cyc(1'b1, 4'b0011, 1'b0, 4'd0, 1'b1, 1'b0);
    n_chk++;
    if (flags !== 4'b0 || stk_depth !== 3'd1) begin
      n_fail++; $display("FAIL coll_we_enter: got flags=%b depth=%0d want 0000 1", flags, stk_depth);
    end
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    n_chk++;
    if (flags !== 4'b0011 || stk_depth !== 3'd0 || stk_err !== 1'b0) begin
      n_fail++; $display("FAIL coll_pushed_val: got flags=%b depth=%0d err=%b want 0011 0 0", flags, stk_depth, stk_err);
    end
    // Query evaluates on pre-exception flags even as enter clears them.
    cyc(1'b1, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, CORE_COND_EQ, 1'b1, 1'b0);
    n_chk++;
    if (taken !== 1'b1 || taken_valid !== 1'b1 || flags !== 4'b0) begin
      n_fail++; $display("FAIL coll_query_enter: got taken=%b tv=%b flags=%b want 1 1 0000", taken, taken_valid, flags);
    end
    cyc(1'b1, 4'b1001, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    n_chk++;
    if (stk_depth !== 3'd2 || stk_err !== 1'b1 || flags !== 4'b0) begin
      n_fail++; $display("FAIL coll_enter_ret: got depth=%0d err=%b flags=%b want 2 1 0000", stk_depth, stk_err, flags);
    end
    cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    n_chk++;
    if (flags !== 4'b1001) begin n_fail++; $display("FAIL coll_enter_ret_pop: got %b want 1001", flags); end
  endtask

  task automatic test_midreset();
    do_reset();
    cyc(1'b1, 4'b1111, 1'b0, 4'd0, 1'b1, 1'b1);
    cyc(1'b1, 4'b0101, 1'b1, CORE_COND_AL, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 4'b1111, 1'b1, 4'd14, 1'b1, 1'b0);
    n_chk++;
    if ({flags, taken_valid, taken, cond_illegal, stk_depth, stk_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL midreset: got flags=%b tv=%b t=%b ill=%b depth=%0d err=%b want all 0",
               flags, taken_valid, taken, cond_illegal, stk_depth, stk_err);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_conds();
    test_nesting();
    test_overflow();
    test_underflow();
    test_collisions();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
